// File: rtl/operand_entry_if.sv
// Operand entry bus: raw switches/buttons in, registered operands and status out.
interface operand_entry_if;
    logic [3:0] sw;
    logic       btn_next;
    logic       btn_op;
    logic [3:0] a;
    logic [3:0] b;
    logic       oper;
    logic       valid;
    logic [1:0] state;

    modport master (output sw, btn_next, btn_op, input a, b, oper, valid, state);
    modport slave  (input sw, btn_next, btn_op, output a, b, oper, valid, state);
endinterface

// File: rtl/operand_entry_ctrl.sv
// Debounced button front end and LOAD_A/LOAD_B/SHOW entry sequencer that
// produces registered operands for the 4-bit add/subtract datapath.
module operand_entry_btn #(
    parameter int DEBOUNCE_CYCLES = 166666,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    logic             s1, s2, stable;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            pulse <= 1'b0;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= s2;
                cnt    <= '0;
                // only the 0->1 acceptance is a press
                pulse  <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module operand_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 166666,
    parameter int CNT_W           = 18
) (
    input  logic              clk,
    input  logic              rst,
    operand_entry_if.slave    bus
);
    localparam int NUM_BTN = 2;

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        SHOW   = 2'b10
    } state_t;

    logic [NUM_BTN-1:0] raw, pulse;
    state_t             st;
    logic [3:0]         a_q, b_q;
    logic               oper_q, valid_q;

    // bit 0 = NEXT, bit 1 = OP
    assign raw = {bus.btn_op, bus.btn_next};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        operand_entry_btn #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_btn (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw[g]),
            .pulse(pulse[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            oper_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            if (pulse[1]) oper_q <= ~oper_q;
            if (pulse[0]) begin
                case (st)
                    LOAD_A: begin a_q <= bus.sw; st <= LOAD_B; end
                    LOAD_B: begin b_q <= bus.sw; st <= SHOW; valid_q <= 1'b1; end
                    SHOW:   begin st <= LOAD_A; valid_q <= 1'b0; end
                    default: begin st <= LOAD_A; valid_q <= 1'b0; end
                endcase
            end else if (st != LOAD_A && st != LOAD_B && st != SHOW) begin
                st      <= LOAD_A;
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.a     = a_q;
    assign bus.b     = b_q;
    assign bus.oper  = oper_q;
    assign bus.valid = valid_q;
    assign bus.state = st;
endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed plus randomized checks of operand_entry_ctrl against a window-based
// behavioural model of debounce and the entry sequence.
module tb_operand_entry_ctrl;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    operand_entry_if bus ();

    operand_entry_ctrl #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // model state
    bit [1:0]    syn [2];
    bit [DC-1:0] win [2];
    bit          stb [2];
    bit          pls [2];
    int          m_state;
    bit [3:0]    m_a, m_b;
    bit          m_oper, m_valid;

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            syn[i] = '0; win[i] = '0; stb[i] = 1'b0; pls[i] = 1'b0;
        end
        m_state = 0; m_a = 0; m_b = 0; m_oper = 1'b1; m_valid = 1'b0;
    endtask

    // one clock edge of the reference: act on last edge's presses, then
    // accept a level once the last DC synchronized samples all disagree with it
    task automatic m_edge();
        bit rawv [2];
        bit s2;
        if (rst) begin m_reset(); return; end
        rawv[0] = bus.btn_next;
        rawv[1] = bus.btn_op;
        if (pls[1]) m_oper = ~m_oper;
        if (pls[0]) begin
            if (m_state == 0) begin m_a = bus.sw; m_state = 1; end
            else if (m_state == 1) begin m_b = bus.sw; m_state = 2; m_valid = 1'b1; end
            else begin m_state = 0; m_valid = 1'b0; end
        end
        for (int i = 0; i < 2; i++) begin
            s2     = syn[i][1];
            syn[i] = {syn[i][0], rawv[i]};
            win[i] = {win[i][DC-2:0], s2};
            pls[i] = 1'b0;
            if (win[i] == {DC{~stb[i]}}) begin
                stb[i] = ~stb[i];
                pls[i] = stb[i];
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("a", bus.a, m_a);
        chk("b", bus.b, m_b);
        chk("oper", {3'b0, bus.oper}, {3'b0, m_oper});
        chk("valid", {3'b0, bus.valid}, {3'b0, m_valid});
        chk("state", {2'b0, bus.state}, 4'(m_state));
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
        chk_model();
    endtask

    task automatic press(input bit nxt, input bit op, input logic [3:0] v);
        bus.sw = v; bus.btn_next = nxt; bus.btn_op = op;
        repeat (10) tick();
        bus.btn_next = 1'b0; bus.btn_op = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        m_reset();
        rst = 1'b1; bus.sw = 4'd0; bus.btn_next = 1'b0; bus.btn_op = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b0;
        repeat (2) tick();
        chk("rst_a", bus.a, 4'd0);
        chk("rst_b", bus.b, 4'd0);
        chk("rst_oper", {3'b0, bus.oper}, 4'd1);
        chk("rst_valid", {3'b0, bus.valid}, 4'd0);
        chk("rst_state", {2'b0, bus.state}, 4'd0);

        // full sequence
        press(1, 0, 4'd5);
        chk("seq_a", bus.a, 4'd5);
        chk("seq_st1", {2'b0, bus.state}, 4'd1);
        press(1, 0, 4'd9);
        chk("seq_b", bus.b, 4'd9);
        chk("seq_st2", {2'b0, bus.state}, 4'd2);
        chk("seq_valid", {3'b0, bus.valid}, 4'd1);
        press(1, 0, 4'd0);
        chk("seq_st0", {2'b0, bus.state}, 4'd0);
        chk("seq_valid0", {3'b0, bus.valid}, 4'd0);
        chk("seq_a_keep", bus.a, 4'd5);
        chk("seq_b_keep", bus.b, 4'd9);

        // bounces shorter than the debounce window
        bus.btn_next = 1'b1; repeat (3) tick();
        bus.btn_next = 1'b0; repeat (3) tick();
        bus.btn_next = 1'b1; repeat (2) tick();
        bus.btn_next = 1'b0; repeat (12) tick();
        chk("glitch_state", {2'b0, bus.state}, 4'd0);

        // latency: press seen at edge k acts on edge k+DC+2
        bus.sw = 4'd7;
        bus.btn_next = 1'b1;
        repeat (DC + 2) tick();
        chk("lat_before", {2'b0, bus.state}, 4'd0);
        tick();
        chk("lat_after", {2'b0, bus.state}, 4'd1);
        chk("lat_a", bus.a, 4'd7);
        repeat (100) tick();
        chk("hold_state", {2'b0, bus.state}, 4'd1);
        bus.btn_next = 1'b0; repeat (10) tick();

        // OP toggles in SHOW
        press(1, 0, 4'd2);
        chk("op_pre_state", {2'b0, bus.state}, 4'd2);
        press(0, 1, 4'd2);
        chk("op_oper0", {3'b0, bus.oper}, 4'd0);
        chk("op_valid", {3'b0, bus.valid}, 4'd1);
        press(0, 1, 4'd2);
        chk("op_oper1", {3'b0, bus.oper}, 4'd1);

        // simultaneous NEXT and OP in LOAD_B
        press(1, 0, 4'd1);
        press(1, 0, 4'd4);
        chk("sim_pre", {2'b0, bus.state}, 4'd1);
        press(1, 1, 4'd3);
        chk("sim_b", bus.b, 4'd3);
        chk("sim_state", {2'b0, bus.state}, 4'd2);
        chk("sim_valid", {3'b0, bus.valid}, 4'd1);
        chk("sim_oper", {3'b0, bus.oper}, 4'd0);

        // async reset mid-debounce while in SHOW
        bus.btn_next = 1'b1;
        repeat (4) tick();
        #3 rst = 1'b1;
        m_reset();
        #1;
        chk("mrst_a", bus.a, 4'd0);
        chk("mrst_b", bus.b, 4'd0);
        chk("mrst_oper", {3'b0, bus.oper}, 4'd1);
        chk("mrst_valid", {3'b0, bus.valid}, 4'd0);
        chk("mrst_state", {2'b0, bus.state}, 4'd0);
        bus.btn_next = 1'b0;
        repeat (2) tick();
        #2 rst = 1'b0;
        repeat (12) tick();
        chk("mrst_nostale", {2'b0, bus.state}, 4'd0);

        // randomized button activity
        for (int seg = 0; seg < 60; seg++) begin
            bus.sw       = 4'($urandom_range(0, 15));
            bus.btn_next = 1'($urandom_range(0, 1));
            bus.btn_op   = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 12)) tick();
        end
        bus.btn_next = 1'b0; bus.btn_op = 1'b0;
        repeat (12) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/operand_entry_ctrl.md
Name: operand_entry_ctrl

Overview:
- Upstream stage of the 4-bit add/subtract datapath: turns raw switches and push-buttons into stable registered operands `a`, `b` and operation select `oper`.
- Debounces two raw buttons (NEXT, OP) and synchronizes them to `clk`.
- Runs a 3-state entry sequence: load A, load B, show result.
- Outputs feed the adder/subtractor directly; `valid` qualifies the result shown on the seven-segment display.

Parameters:
- DEBOUNCE_CYCLES, 166666: consecutive synchronized cycles a button level must hold before it is accepted (min 2).
- CNT_W, 18: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- sw  input  4  raw operand switches
- btn_next  input  1  raw NEXT button, active-high, asynchronous to clk
- btn_op  input  1  raw OP button, active-high, asynchronous to clk
- a  output  4  registered operand A to adder
- b  output  4  registered operand B to adder
- oper  output  1  1 = add, 0 = subtract (adder convention)
- valid  output  1  high while in SHOW; result on display is meaningful
- state  output  2  00 LOAD_A, 01 LOAD_B, 10 SHOW (drives status LEDs)

Behaviour:
- Reset is asynchronous, active-high, and applies the same values at any time, including mid-debounce or mid-sequence:
  - a = 0, b = 0, oper = 1, valid = 0, state = LOAD_A.
  - Synchronizers, stable levels, counters and pulses all clear to 0.
- Button path, per button, identical for both:
  - 2-flop synchronizer s1 → s2.
  - Debounce: stable level register plus CNT_W counter.
    - If s2 == stable: counter ← 0.
    - If s2 != stable and counter == DEBOUNCE_CYCLES-1: stable ← s2, counter ← 0.
    - Otherwise: counter ← counter+1.
  - Press pulse is registered and asserted for exactly 1 cycle, on the same edge stable goes 0→1. Release (1→0) produces no pulse.
  - Latency: a raw level held high from before clk edge k gives pulse high in the cycle after edge k+DEBOUNCE_CYCLES+1.
  - Glitches shorter than DEBOUNCE_CYCLES synchronized cycles give no pulse; the counter restarts on any bounce.
  - Holding the button produces only one pulse; a new pulse requires a debounced release first.
- FSM, advanced by the NEXT pulse:
  - LOAD_A + next: a ← sw; go to LOAD_B.
  - LOAD_B + next: b ← sw; go to SHOW; valid ← 1.
  - SHOW + next: go to LOAD_A; valid ← 0. a and b hold their old values until overwritten.
  - No next pulse: hold state and all registers.
- OP pulse: oper ← ~oper in any state. valid is unaffected, so a SHOW result updates live.
- Simultaneous NEXT and OP pulses in the same cycle: both take effect on that edge.
- `sw` is sampled without synchronization, only on the next-pulse edge. The switches are assumed static during a press.
- All outputs are registered; no combinational path from inputs to outputs.
- `state` encoding 11 is unreachable; if entered, go to LOAD_A with valid ← 0 on the next edge.

Test Plan (DEBOUNCE_CYCLES = 4):
1. Reset then idle → a=0, b=0, oper=1, valid=0, state=00.
2. Full sequence:
   - sw=5, hold btn_next ≥10 cycles, release ≥10 → a=5, state=01.
   - sw=9, same press → b=9, state=10, valid=1.
   - Third press → state=00, valid=0, a=5, b=9 retained.
3. Debounce:
   - btn_next pulsed high 3 cycles, low 3, high 2 → no pulse, state unchanged.
   - Clean high held from before edge k → pulse in the cycle after edge k+5, exactly 1 cycle wide.
   - Holding 100 cycles → only one advance.
4. OP toggle:
   - Press btn_op in SHOW → oper 1→0, valid stays 1.
   - Second press → oper=1.
5. Simultaneous: btn_next and btn_op rise on the same edge in LOAD_B with sw=3 → same edge gives b=3, state=10, valid=1, oper toggled.
6. Reset mid-operation: assert rst asynchronously (between clk edges) while in SHOW with a debounce count in progress → outputs reset immediately; after release, no stale pulse and state=00.
